pipeline_hazard_controller: RTL and testbench

- Central stall/flush/freeze sequencer for the 5-stage pipeline (IF, ID, EXE, MEM, WB). It sits beside the forwarding-select logic.
- Detects RAW hazards at ID, in either forwarding mode. Applies branch flushes. Freezes the whole pipe while the MEM-stage memory access is outstanding.
- A small FSM tracks memory waits and enforces a timeout. Every pipeline register's freeze/flush/bubble control comes from this block.

---
 rtl/pipe_ctrl_pkg.sv | 26 ++
 rtl/hazard_detect.sv | 41 ++++
 rtl/pipeline_hazard_controller.sv | 157 +++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// default register-address width and the wait-counter width helper.
package pipe_ctrl_pkg;

    localparam int REG_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } pipe_state_e;

    // Bits needed to hold any value in 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational read-after-write detector for the instruction sitting in ID.
// With forwarding only a load in EXE forces a stall; without forwarding any
// pending write in EXE or MEM to a register ID reads forces a stall.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEFAULT
) (
    input  logic             forward_en,
    input  logic             id_valid,
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic             two_src,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    output logic             hazard
);

    logic exe_hit;
    logic mem_hit;

    // src2 only matters when the instruction really reads it
    assign exe_hit = (src1 == exe_dest) | (two_src & (src2 == exe_dest));
    assign mem_hit = (src1 == mem_dest) | (two_src & (src2 == mem_dest));

    // Select the hazard rule for the current forwarding mode
    always_comb begin
        hazard = 1'b0;
        if (id_valid) begin
            if (forward_en) begin
                hazard = exe_wb_en & exe_mem_r_en & exe_hit;
            end else begin
                hazard = (exe_wb_en & exe_hit) | (mem_wb_en & mem_hit);
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall / flush / freeze sequencer for the 5-stage pipeline.
// Priority: memory freeze > branch flush > data stall. A small FSM tracks
// outstanding MEM accesses and traps into ERROR after TIMEOUT_CYCLES frozen
// cycles. Optional saturating perf counters are built when HAZARD_PERF_EN is
// defined.
module pipeline_hazard_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W          = REG_W_DEFAULT,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int PERF_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             forward_en,
    input  logic             id_valid,
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic             two_src,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             freeze_pc,
    output logic             freeze_if_id,
    output logic             bubble_id_ex,
    output logic             flush_if_id,
    output logic             freeze_pipe,
    output logic             mem_timeout,
    output logic [1:0]       ctrl_state
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cyc,
    output logic [PERF_W-1:0] perf_flush_cnt,
    output logic [PERF_W-1:0] perf_memwait_cyc
`endif
);

    localparam logic [1:0] ST_RUN      = RUN;
    localparam logic [1:0] ST_MEM_WAIT = MEM_WAIT;
    localparam logic [1:0] ST_ERROR    = ERROR;

    localparam int CNT_W = clog2(TIMEOUT_CYCLES);
    // The RUN cycle that launches the wait is already frozen, so the trap
    // fires from the MEM_WAIT cycle that completes TIMEOUT_CYCLES freezes.
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 2);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_next;
    logic             hazard;
    logic             freeze_int;
    logic             flush_int;
    logic             stall_int;

    hazard_detect #(
        .REG_W(REG_W)
    ) u_hazard_detect (
        .forward_en  (forward_en),
        .id_valid    (id_valid),
        .src1        (src1),
        .src2        (src2),
        .two_src     (two_src),
        .exe_dest    (exe_dest),
        .exe_wb_en   (exe_wb_en),
        .exe_mem_r_en(exe_mem_r_en),
        .mem_dest    (mem_dest),
        .mem_wb_en   (mem_wb_en),
        .hazard      (hazard)
    );

    // Memory-wait FSM: next state, wait counter and whole-pipe freeze
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        freeze_int    = 1'b0;
        case (state)
            ST_RUN: begin
                wait_cnt_next = '0;
                if (mem_req && !mem_ready) begin
                    freeze_int = 1'b1;
                    state_next = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_req || mem_ready) begin
                    state_next    = ST_RUN;
                    wait_cnt_next = '0;
                end else if (wait_cnt == LAST_WAIT) begin
                    freeze_int = 1'b1;
                    state_next = ST_ERROR;
                end else begin
                    freeze_int    = 1'b1;
                    wait_cnt_next = wait_cnt + CNT_W'(1);
                end
            end
            ST_ERROR: begin
                freeze_int = 1'b1;
            end
            default: begin
                state_next    = ST_RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    // A frozen EXE keeps branch_taken asserted, so the flush lands on the
    // first unfrozen cycle without any extra storage here.
    assign flush_int = ~rst & ~freeze_int & branch_taken;
    assign stall_int = ~rst & ~freeze_int & ~branch_taken & hazard;

    assign freeze_pipe  = ~rst & freeze_int;
    assign flush_if_id  = flush_int;
    assign bubble_id_ex = flush_int | stall_int;
    assign freeze_pc    = stall_int;
    assign freeze_if_id = stall_int;
    assign mem_timeout  = (state == ST_ERROR);
    assign ctrl_state   = state;

    // State and wait-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating event counters, each stepping only when its output asserts
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cyc   <= '0;
            perf_flush_cnt   <= '0;
            perf_memwait_cyc <= '0;
        end else begin
            if (stall_int && (perf_stall_cyc != '1)) begin
                perf_stall_cyc <= perf_stall_cyc + PERF_W'(1);
            end
            if (flush_int && (perf_flush_cnt != '1)) begin
                perf_flush_cnt <= perf_flush_cnt + PERF_W'(1);
            end
            if (freeze_pipe && (perf_memwait_cyc != '1)) begin
                perf_memwait_cyc <= perf_memwait_cyc + PERF_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller (TIMEOUT_CYCLES = 8).
// Stimulus is applied just after each rising edge and the expected outputs
// for that cycle are queued; a monitor pops and compares on the falling edge.
// Expected vector layout: {ctrl_state[1:0], mem_timeout, freeze_pipe,
// flush_if_id, bubble_id_ex, freeze_if_id, freeze_pc}.
module tb_pipeline_hazard_controller;

    localparam int REG_W  = 4;
    localparam int PERF_W = 32;
    localparam logic [7:0] ALL  = 8'hFF;
    localparam logic [7:0] COMB = 8'h1F;

    typedef struct {
        logic             rst;
        logic             forward_en;
        logic             id_valid;
        logic [REG_W-1:0] src1;
        logic [REG_W-1:0] src2;
        logic             two_src;
        logic [REG_W-1:0] exe_dest;
        logic             exe_wb_en;
        logic             exe_mem_r_en;
        logic [REG_W-1:0] mem_dest;
        logic             mem_wb_en;
        logic             branch_taken;
        logic             mem_req;
        logic             mem_ready;
    } stim_t;

    typedef struct {
        string      name;
        logic [7:0] exp_vec;
        logic [7:0] care;
        bit         chk_perf;
        int         exp_stall;
        int         exp_flush;
        int         exp_mem;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             forward_en;
    logic             id_valid;
    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic             two_src;
    logic [REG_W-1:0] exe_dest;
    logic             exe_wb_en;
    logic             exe_mem_r_en;
    logic [REG_W-1:0] mem_dest;
    logic             mem_wb_en;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             freeze_pc;
    logic             freeze_if_id;
    logic             bubble_id_ex;
    logic             flush_if_id;
    logic             freeze_pipe;
    logic             mem_timeout;
    logic [1:0]       ctrl_state;
`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] perf_stall_cyc;
    logic [PERF_W-1:0] perf_flush_cnt;
    logic [PERF_W-1:0] perf_memwait_cyc;
`endif

    stim_t st;
    exp_t  sb_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    perf_chk = 1'b0;
    int    perf_stall_exp = 0;
    int    perf_flush_exp = 0;
    int    perf_mem_exp = 0;

    pipeline_hazard_controller #(
        .REG_W         (REG_W),
        .TIMEOUT_CYCLES(8),
        .PERF_W        (PERF_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .forward_en  (forward_en),
        .id_valid    (id_valid),
        .src1        (src1),
        .src2        (src2),
        .two_src     (two_src),
        .exe_dest    (exe_dest),
        .exe_wb_en   (exe_wb_en),
        .exe_mem_r_en(exe_mem_r_en),
        .mem_dest    (mem_dest),
        .mem_wb_en   (mem_wb_en),
        .branch_taken(branch_taken),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .freeze_pc   (freeze_pc),
        .freeze_if_id(freeze_if_id),
        .bubble_id_ex(bubble_id_ex),
        .flush_if_id (flush_if_id),
        .freeze_pipe (freeze_pipe),
        .mem_timeout (mem_timeout),
        .ctrl_state  (ctrl_state)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cyc  (perf_stall_cyc),
        .perf_flush_cnt  (perf_flush_cnt),
        .perf_memwait_cyc(perf_memwait_cyc)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp8(input logic pc, input logic ifid, input logic bub,
                                        input logic fl, input logic fp, input logic to,
                                        input logic [1:0] cs);
        return {cs, to, fp, fl, bub, ifid, pc};
    endfunction

    function automatic stim_t idle_stim();
        stim_t s;
        s.rst = 1'b0; s.forward_en = 1'b0; s.id_valid = 1'b0;
        s.src1 = '0; s.src2 = '0; s.two_src = 1'b0;
        s.exe_dest = '0; s.exe_wb_en = 1'b0; s.exe_mem_r_en = 1'b0;
        s.mem_dest = '0; s.mem_wb_en = 1'b0;
        s.branch_taken = 1'b0; s.mem_req = 1'b0; s.mem_ready = 1'b0;
        return s;
    endfunction

    // Drive one cycle of stimulus and queue the outputs expected for it
    task automatic applyStimulus(input string name, input logic [7:0] exp_vec,
                                 input logic [7:0] care);
        exp_t e;
        @(posedge clk);
        #1;
        rst = st.rst; forward_en = st.forward_en; id_valid = st.id_valid;
        src1 = st.src1; src2 = st.src2; two_src = st.two_src;
        exe_dest = st.exe_dest; exe_wb_en = st.exe_wb_en; exe_mem_r_en = st.exe_mem_r_en;
        mem_dest = st.mem_dest; mem_wb_en = st.mem_wb_en;
        branch_taken = st.branch_taken; mem_req = st.mem_req; mem_ready = st.mem_ready;
        e.name = name; e.exp_vec = exp_vec; e.care = care;
        e.chk_perf = perf_chk; e.exp_stall = perf_stall_exp;
        e.exp_flush = perf_flush_exp; e.exp_mem = perf_mem_exp;
        perf_chk = 1'b0;
        sb_q.push_back(e);
    endtask

    // Compare the current DUT outputs against one scoreboard entry
    task automatic checkOutput(input exp_t e);
        logic [7:0] act;
        act = {ctrl_state, mem_timeout, freeze_pipe, flush_if_id, bubble_id_ex,
               freeze_if_id, freeze_pc};
        checks++;
        if (((act ^ e.exp_vec) & e.care) !== 8'h00) begin
            errors++;
            $display("[TB] FAIL %s: got=%b required=%b care=%b", e.name, act, e.exp_vec, e.care);
        end
`ifdef HAZARD_PERF_EN
        if (e.chk_perf) begin
            checks++;
            if (perf_stall_cyc !== PERF_W'(e.exp_stall) || perf_flush_cnt !== PERF_W'(e.exp_flush)
                || perf_memwait_cyc !== PERF_W'(e.exp_mem)) begin
                errors++;
                $display("[TB] FAIL %s_perf: got stall=%0d flush=%0d mem=%0d required %0d %0d %0d",
                         e.name, perf_stall_cyc, perf_flush_cnt, perf_memwait_cyc,
                         e.exp_stall, e.exp_flush, e.exp_mem);
            end
        end
`endif
    endtask

    // Monitor: one comparison per falling edge while entries are pending
    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                checkOutput(sb_q.pop_front());
            end
        end
    end

    initial begin
        st = idle_stim();
        st.rst = 1'b1;
        rst = 1'b1; forward_en = 1'b0; id_valid = 1'b0; src1 = '0; src2 = '0;
        two_src = 1'b0; exe_dest = '0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
        mem_dest = '0; mem_wb_en = 1'b0; branch_taken = 1'b0; mem_req = 1'b0;
        mem_ready = 1'b0;

        // Reset: all control outputs low even with active requests
        st.branch_taken = 1'b1; st.mem_req = 1'b1;
        st.forward_en = 1'b1; st.id_valid = 1'b1; st.exe_wb_en = 1'b1;
        st.exe_mem_r_en = 1'b1; st.exe_dest = 4'd3; st.src1 = 4'd3;
        applyStimulus("reset_0", exp8(0,0,0,0,0,0,2'd0), ALL);
        applyStimulus("reset_1", exp8(0,0,0,0,0,0,2'd0), ALL);
        st = idle_stim();
        applyStimulus("idle", exp8(0,0,0,0,0,0,2'd0), ALL);

        // Forwarding mode: only load-use stalls
        st.forward_en = 1'b1; st.id_valid = 1'b1; st.exe_wb_en = 1'b1;
        st.exe_mem_r_en = 1'b1; st.exe_dest = 4'd3; st.src1 = 4'd3;
        applyStimulus("load_use", exp8(1,1,1,0,0,0,2'd0), ALL);
        st.src1 = 4'd4;
        applyStimulus("load_use_miss", exp8(0,0,0,0,0,0,2'd0), ALL);
        st.src2 = 4'd3; st.two_src = 1'b1;
        applyStimulus("load_use_src2", exp8(1,1,1,0,0,0,2'd0), ALL);
        st.src1 = 4'd3; st.exe_mem_r_en = 1'b0;
        applyStimulus("fwd_alu_no_stall", exp8(0,0,0,0,0,0,2'd0), ALL);
        st.exe_mem_r_en = 1'b1; st.id_valid = 1'b0;
        applyStimulus("id_invalid", exp8(0,0,0,0,0,0,2'd0), ALL);

        // No forwarding: any pending write in EXE or MEM stalls
        st = idle_stim();
        st.id_valid = 1'b1; st.mem_wb_en = 1'b1; st.mem_dest = 4'd5;
        st.src2 = 4'd5; st.two_src = 1'b1;
        applyStimulus("nofwd_mem_src2", exp8(1,1,1,0,0,0,2'd0), ALL);
        st.two_src = 1'b0;
        applyStimulus("nofwd_src2_unused", exp8(0,0,0,0,0,0,2'd0), ALL);
        st = idle_stim();
        st.id_valid = 1'b1; st.exe_wb_en = 1'b1; st.exe_dest = 4'd7; st.src1 = 4'd7;
        applyStimulus("nofwd_exe_src1", exp8(1,1,1,0,0,0,2'd0), ALL);

        // Single-cycle access: no freeze, stay in RUN
        st = idle_stim();
        st.mem_req = 1'b1; st.mem_ready = 1'b1;
        applyStimulus("mem_single", exp8(0,0,0,0,0,0,2'd0), ALL);
        st = idle_stim();
        applyStimulus("mem_single_after", exp8(0,0,0,0,0,0,2'd0), ALL);

        // Four-cycle wait then ready: states 0,1,1,1,1,0
        st.mem_req = 1'b1;
        applyStimulus("memwait_0", exp8(0,0,0,0,1,0,2'd0), ALL);
        applyStimulus("memwait_1", exp8(0,0,0,0,1,0,2'd1), ALL);
        applyStimulus("memwait_2", exp8(0,0,0,0,1,0,2'd1), ALL);
        applyStimulus("memwait_3", exp8(0,0,0,0,1,0,2'd1), ALL);
        st.mem_ready = 1'b1;
        applyStimulus("memwait_ready", exp8(0,0,0,0,0,0,2'd1), ALL);
        st = idle_stim();
        applyStimulus("memwait_done", exp8(0,0,0,0,0,0,2'd0), ALL);

        // Request withdrawn while waiting
        st.mem_req = 1'b1;
        applyStimulus("drop_0", exp8(0,0,0,0,1,0,2'd0), ALL);
        st.mem_req = 1'b0;
        applyStimulus("drop_1", exp8(0,0,0,0,0,0,2'd1), ALL);
        applyStimulus("drop_2", exp8(0,0,0,0,0,0,2'd0), ALL);

        // Branch held during freeze flushes on the ready cycle
        st.mem_req = 1'b1; st.branch_taken = 1'b1;
        applyStimulus("br_frozen_0", exp8(0,0,0,0,1,0,2'd0), ALL);
        applyStimulus("br_frozen_1", exp8(0,0,0,0,1,0,2'd1), ALL);
        st.mem_ready = 1'b1;
        applyStimulus("br_release", exp8(0,0,1,1,0,0,2'd1), ALL);
        st = idle_stim();
        applyStimulus("br_after", exp8(0,0,0,0,0,0,2'd0), ALL);

        // Branch and load-use hazard together: flush only
        st.rst = 1'b1;
        applyStimulus("rst_pulse_a", exp8(0,0,0,0,0,0,2'd0), ALL);
        st = idle_stim();
        st.branch_taken = 1'b1; st.forward_en = 1'b1; st.id_valid = 1'b1;
        st.exe_wb_en = 1'b1; st.exe_mem_r_en = 1'b1; st.exe_dest = 4'd3; st.src1 = 4'd3;
        applyStimulus("branch_and_hazard", exp8(0,0,1,1,0,0,2'd0), ALL);
        st = idle_stim();
        perf_chk = 1'b1; perf_stall_exp = 0; perf_flush_exp = 1; perf_mem_exp = 0;
        applyStimulus("branch_and_hazard_next", exp8(0,0,0,0,0,0,2'd0), ALL);

        // Timeout: 8 frozen cycles then sticky ERROR
        st.mem_req = 1'b1;
        applyStimulus("timeout_c1", exp8(0,0,0,0,1,0,2'd0), ALL);
        for (int i = 2; i <= 8; i++) begin
            applyStimulus($sformatf("timeout_c%0d", i), exp8(0,0,0,0,1,0,2'd1), ALL);
        end
        applyStimulus("error_entered", exp8(0,0,0,0,1,1,2'd2), ALL);
        st.mem_ready = 1'b1; st.branch_taken = 1'b1; st.forward_en = 1'b1;
        st.id_valid = 1'b1; st.exe_wb_en = 1'b1; st.exe_mem_r_en = 1'b1;
        st.exe_dest = 4'd3; st.src1 = 4'd3;
        applyStimulus("error_sticky", exp8(0,0,0,0,1,1,2'd2), ALL);
        st = idle_stim();
        applyStimulus("error_idle", exp8(0,0,0,0,1,1,2'd2), ALL);
        st.rst = 1'b1;
        applyStimulus("error_rst", exp8(0,0,0,0,0,0,2'd0), COMB);
        st = idle_stim();
        applyStimulus("after_error_rst", exp8(0,0,0,0,0,0,2'd0), ALL);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) begin
            @(posedge clk);
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: pending=%0d required=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
